oscillator_bank: RTL and testbench

Multi-channel, fully synthesizable fixed-point damped oscillator bank: the next generation of the single real-valued oscillator. Keeps the same per-step dynamics (position integrates velocity; velocity integrates a damped spring acceleration plus scaled external feedback) for CHANNELS independent oscillators. All channels share one time-multiplexed arithmetic datapath, one channel per cycle. Sits between the controller that issues step strobes and per-channel feedback and the consumers of the 8-bit position outputs.

---
 rtl/osc_pkg.sv | 37 +++
 rtl/osc_step_alu.sv | 52 +++++
 rtl/oscillator_bank.sv | 121 ++++++++++++
 tb/tb_oscillator_bank.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/osc_pkg.sv
// Shared types and fixed-point helpers for the oscillator bank.
package osc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int unsigned FB_BITS  = 8;
  localparam int unsigned OUT_BITS = 8;
  localparam int unsigned OUT_FRAC = 7;

  function automatic logic signed [63:0] sat_width(input logic signed [63:0] x,
                                                   input int unsigned         w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) begin
      return hi;
    end else if (x < lo) begin
      return lo;
    end
    return x;
  endfunction

  function automatic logic signed [OUT_BITS-1:0] sat8(input logic signed [63:0] x);
    if (x > 64'sd127) begin
      return 8'sd127;
    end else if (x < -64'sd128) begin
      return -8'sd128;
    end
    return x[OUT_BITS-1:0];
  endfunction

endpackage

// File: rtl/osc_step_alu.sv
// One damped-oscillator step: (p, v, fb) -> (p', v', saturated 8-bit position).
module osc_step_alu
  import osc_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 24,
  parameter int unsigned FRAC     = 16,
  parameter int unsigned KV_SHIFT = 7,
  parameter int unsigned KP_SHIFT = 11,
  parameter int unsigned FB_SHIFT = 10,
  parameter int          NEUTRAL  = 0,
  parameter int          INIT_POS = 19661
) (
  input  logic signed [WIDTH-1:0]    p,
  input  logic signed [WIDTH-1:0]    v,
  input  logic signed [FB_BITS-1:0]  fb,
  output logic signed [WIDTH-1:0]    p_next,
  output logic signed [WIDTH-1:0]    v_next,
  output logic signed [OUT_BITS-1:0] out8
);

  localparam int unsigned XW = WIDTH + 2;
  localparam logic signed [XW-1:0] NEUTRAL_X = XW'(NEUTRAL);

  if (CHANNELS < 1 || FRAC < OUT_FRAC || INIT_POS < -(2 ** (WIDTH - 1)) ||
      INIT_POS > (2 ** (WIDTH - 1)) - 1) begin : g_param_check
    $error("osc_step_alu: illegal parameter set");
  end

  logic signed [XW-1:0] px;
  logic signed [XW-1:0] vx;
  logic signed [XW-1:0] fbx;
  logic signed [XW-1:0] fbs;
  logic signed [XW-1:0] acc;
  logic signed [XW-1:0] psum;
  logic signed [XW-1:0] vsum;

  // Widen, integrate, clamp back to WIDTH, then derive the Q1.7 output.
  always_comb begin
    px     = {{2{p[WIDTH-1]}}, p};
    vx     = {{2{v[WIDTH-1]}}, v};
    fbx    = {{(XW - FB_BITS){fb[FB_BITS-1]}}, fb};
    fbs    = (fbx <<< (FRAC - OUT_FRAC)) >>> FB_SHIFT;
    acc    = -(vx >>> KV_SHIFT) - ((px - NEUTRAL_X) >>> KP_SHIFT) + fbs;
    psum   = px + vx;
    vsum   = vx + acc;
    p_next = WIDTH'(sat_width(64'(psum), WIDTH));
    v_next = WIDTH'(sat_width(64'(vsum), WIDTH));
    out8   = sat8(64'(p_next) >>> (FRAC - OUT_FRAC));
  end

endmodule

// File: rtl/oscillator_bank.sv
// Multi-channel damped oscillator bank sharing one time-multiplexed step ALU.
module oscillator_bank
  import osc_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 24,
  parameter int unsigned FRAC     = 16,
  parameter int unsigned KV_SHIFT = 7,
  parameter int unsigned KP_SHIFT = 11,
  parameter int unsigned FB_SHIFT = 10,
  parameter int          NEUTRAL  = 0,
  parameter int          INIT_POS = 19661,
  localparam int unsigned LCW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           step,
  input  logic [CHANNELS*FB_BITS-1:0]    feedback,
  input  logic                           load_valid,
  input  logic [LCW-1:0]                 load_channel,
  input  logic signed [WIDTH-1:0]        load_position,
  output logic                           busy,
  output logic                           done,
  output logic [CHANNELS*OUT_BITS-1:0]   positionOut
);

  localparam logic [LCW-1:0]             CH_LAST  = LCW'(CHANNELS - 1);
  localparam logic signed [WIDTH-1:0]    INIT_X   = WIDTH'(INIT_POS);
  localparam logic signed [OUT_BITS-1:0] INIT_OUT = sat8(64'(INIT_POS) >>> (FRAC - OUT_FRAC));

  state_t state_q;
  state_t state_d;
  logic [LCW-1:0] ch_q;

  logic signed [WIDTH-1:0]    pos_q [CHANNELS];
  logic signed [WIDTH-1:0]    vel_q [CHANNELS];
  logic signed [OUT_BITS-1:0] out_q [CHANNELS];

  logic signed [FB_BITS-1:0]  fb_sel;
  logic signed [WIDTH-1:0]    p_next;
  logic signed [WIDTH-1:0]    v_next;
  logic signed [OUT_BITS-1:0] out8;
  logic signed [OUT_BITS-1:0] load_out;
  logic [31:0]                load_idx;
  logic                       load_ok;

  assign fb_sel   = feedback[FB_BITS*32'(ch_q) +: FB_BITS];
  assign load_out = sat8(64'(load_position) >>> (FRAC - OUT_FRAC));
  assign load_idx = 32'(load_channel);
  assign load_ok  = (load_idx < CHANNELS);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

  osc_step_alu #(
    .CHANNELS (CHANNELS),
    .WIDTH    (WIDTH),
    .FRAC     (FRAC),
    .KV_SHIFT (KV_SHIFT),
    .KP_SHIFT (KP_SHIFT),
    .FB_SHIFT (FB_SHIFT),
    .NEUTRAL  (NEUTRAL),
    .INIT_POS (INIT_POS)
  ) u_alu (
    .p      (pos_q[ch_q]),
    .v      (vel_q[ch_q]),
    .fb     (fb_sel),
    .p_next (p_next),
    .v_next (v_next),
    .out8   (out8)
  );

  // Sweep sequencing; a simultaneous load request suppresses the step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (step && !load_valid) state_d = UPDATE;
      UPDATE:  if (ch_q == CH_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and channel counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == UPDATE && ch_q != CH_LAST) begin
        ch_q <= ch_q + 1'b1;
      end else begin
        ch_q <= '0;
      end
    end
  end

  // Per-channel state: sweep write-back or idle-time load.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        pos_q[i] <= INIT_X;
        vel_q[i] <= '0;
        out_q[i] <= INIT_OUT;
      end
    end else if (state_q == UPDATE) begin
      pos_q[ch_q] <= p_next;
      vel_q[ch_q] <= v_next;
      out_q[ch_q] <= out8;
    end else if (state_q == IDLE && load_valid && load_ok) begin
      pos_q[load_channel] <= load_position;
      vel_q[load_channel] <= '0;
      out_q[load_channel] <= load_out;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_out
    assign positionOut[OUT_BITS*g +: OUT_BITS] = out_q[g];
  end

endmodule

// File: tb/tb_oscillator_bank.sv
module tb_oscillator_bank;

  localparam int CH = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          step = 1'b0;
  logic [31:0]   feedback = '0;
  logic          load_valid = 1'b0;
  logic [1:0]    load_channel = '0;
  logic signed [23:0] load_position = '0;
  logic          busy;
  logic          done;
  logic [31:0]   positionOut;

  int checks = 0;
  int errors = 0;

  oscillator_bank #(
    .CHANNELS (CH),
    .WIDTH    (24),
    .FRAC     (16),
    .KV_SHIFT (7),
    .KP_SHIFT (11),
    .FB_SHIFT (10),
    .NEUTRAL  (0),
    .INIT_POS (19661)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .step          (step),
    .feedback      (feedback),
    .load_valid    (load_valid),
    .load_channel  (load_channel),
    .load_position (load_position),
    .busy          (busy),
    .done          (done),
    .positionOut   (positionOut)
  );

  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic signed [7:0] outk(input int k);
    return positionOut[8*k +: 8];
  endfunction

  function automatic logic signed [23:0] posk(input int k);
    return dut.pos_q[k];
  endfunction

  function automatic logic signed [23:0] velk(input int k);
    return dut.vel_q[k];
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic do_load(input int k, input int pos);
    load_valid    = 1'b1;
    load_channel  = 2'(k);
    load_position = 24'(pos);
    tick();
    load_valid = 1'b0;
  endtask

  // lat: cycles after the step edge until done is seen; bcnt: busy cycles.
  // poke drives a step and a ch0 load in the first busy cycle.
  task automatic do_step(input bit poke, output int lat, output int bcnt);
    step = 1'b1;
    tick();
    step = 1'b0;
    lat  = -1;
    bcnt = 0;
    for (int i = 0; i < 3 * CH + 10; i++) begin
      if (done && lat < 0) lat = i;
      if (!busy) break;
      bcnt++;
      if (poke && i == 0) begin
        step          = 1'b1;
        load_valid    = 1'b1;
        load_channel  = 2'd0;
        load_position = '0;
      end
      tick();
      step       = 1'b0;
      load_valid = 1'b0;
    end
  endtask

  function automatic longint sat24(input longint x);
    if (x > 64'sd8388607) return 64'sd8388607;
    if (x < -64'sd8388608) return -64'sd8388608;
    return x;
  endfunction

  initial begin
    int lat;
    int bc;
    int dcount;
    int tmo;
    longint pm;
    longint vm;
    longint acc;
    longint om;
    int winmax;
    int prevmax;
    int a;

    // Reset state
    do_reset();
    for (int k = 0; k < CH; k++) check($sformatf("rst_out%0d", k), outk(k), 38);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    // First step, no feedback
    do_step(1'b0, lat, bc);
    check("step1_lat", lat, CH);
    check("step1_busy_cycles", bc, CH + 1);
    check("step1_idle_done", done, 0);
    for (int k = 0; k < CH; k++) begin
      check($sformatf("s1_pos%0d", k), posk(k), 19661);
      check($sformatf("s1_vel%0d", k), velk(k), -9);
      check($sformatf("s1_out%0d", k), outk(k), 38);
    end

    // Load ch2 at rest position zero
    do_reset();
    do_load(2, 0);
    check("ld2_out", outk(2), 0);
    do_step(1'b0, lat, bc);
    check("ld2_pos2", posk(2), 0);
    check("ld2_vel2", velk(2), 0);
    check("ld2_out2", outk(2), 0);
    check("ld2_pos0", posk(0), 19661);
    check("ld2_vel0", velk(0), -9);

    // Feedback: +127 on ch1 (loaded 0), -128 on ch2, 0 on ch0
    do_reset();
    do_load(1, 0);
    feedback = 32'h0080_7F00;
    do_step(1'b0, lat, bc);
    check("fb1_vel1", velk(1), 63);
    check("fb1_pos1", posk(1), 0);
    check("fbn1_vel2", velk(2), -73);
    do_step(1'b0, lat, bc);
    check("fb2_pos1", posk(1), 63);
    check("fb2_vel1", velk(1), 126);
    check("fb2_out1", outk(1), 0);
    check("fbn2_pos2", posk(2), 19588);
    check("fbn2_vel2", velk(2), -145);
    check("s2_pos0", posk(0), 19652);
    check("s2_vel0", velk(0), -17);
    feedback = '0;

    // Extremes
    do_reset();
    do_load(0, 8388607);
    check("max_out", outk(0), 127);
    do_load(3, -8388608);
    check("min_out", outk(3), -128);
    do_step(1'b0, lat, bc);
    check("max_pos", posk(0), 8388607);
    check("max_vel", velk(0), -4095);
    check("max_out_step", outk(0), 127);
    check("min_pos", posk(3), -8388608);
    check("min_vel", velk(3), 4096);
    check("min_out_step", outk(3), -128);

    // Step and load during a sweep are ignored
    do_reset();
    do_step(1'b1, lat, bc);
    check("poke_lat", lat, CH);
    check("poke_busy_cycles", bc, CH + 1);
    check("poke_pos0", posk(0), 19661);
    check("poke_vel0", velk(0), -9);
    tick();
    check("poke_not_queued", busy, 0);

    // Reset in the middle of a sweep
    do_reset();
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    tick();
    check("mid_ch", dut.ch_q, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    for (int k = 0; k < CH; k++) begin
      check($sformatf("mid_pos%0d", k), posk(k), 19661);
      check($sformatf("mid_vel%0d", k), velk(k), 0);
      check($sformatf("mid_out%0d", k), outk(k), 38);
    end
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      if (done || busy) dcount++;
      tick();
    end
    check("mid_no_done", dcount, 0);

    // Long free decay against a reference of the step equations
    do_reset();
    pm = 19661;
    vm = 0;
    tmo = 0;
    winmax = 0;
    prevmax = 1000;
    for (int s = 0; s < 4000; s++) begin
      do_step(1'b0, lat, bc);
      if (lat != CH) tmo++;
      acc = -(vm >>> 7) - (pm >>> 11);
      pm  = sat24(pm + vm);
      vm  = sat24(vm + acc);
      for (int k = 0; k < CH; k++) begin
        a = int'(outk(k));
        if (a < 0) a = -a;
        if (a > winmax) winmax = a;
      end
      if ((s + 1) % 500 == 0) begin
        check($sformatf("decay_win%0d", (s + 1) / 500), (winmax <= prevmax), 1);
        prevmax = winmax;
        winmax  = 0;
      end
    end
    check("decay_timeouts", tmo, 0);
    om = pm >>> 9;
    if (om > 127) om = 127;
    if (om < -128) om = -128;
    for (int k = 0; k < CH; k++) begin
      check($sformatf("decay_pos%0d", k), posk(k), pm);
      check($sformatf("decay_vel%0d", k), velk(k), vm);
      check($sformatf("decay_out%0d", k), outk(k), om);
      a = int'(outk(k));
      if (a < 0) a = -a;
      check($sformatf("decay_small%0d", k), (a <= 3), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
